// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter granting one of four requesters the eight-digit hex display.
// A holder keeps the display for at least HOLD_CYCLES+1 cycles under contention.
module hex_display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 1000
) (
    input  logic         inClk,
    input  logic         inRstn,
    input  logic [3:0]   inReq,
    input  logic [127:0] inData,
    input  logic         inFreeze,
    output logic [3:0]   outGrant,
    output logic [31:0]  outValue,
    output logic         outBusy
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;

    logic [1:0]       r_state, r_state_d;
    logic [1:0]       r_last, r_last_d;
    logic [CNT_W-1:0] r_cnt, r_cnt_d;
    logic [3:0]       r_grant, r_grant_d;
    logic [31:0]      r_value, r_value_d;

    logic [1:0]  w_winner;
    logic        w_found;
    logic [31:0] w_win_slice;
    logic [31:0] w_gnt_slice;
    logic        w_req_held;
    logic        w_other;
    logic        w_sat;

    // Search starts just after the last winner, so the previous holder comes last.
    always_comb begin
        logic [1:0] idx;
        w_winner = r_last;
        w_found  = 1'b0;
        idx      = r_last;
        for (int i = 0; i < 4; i++) begin
            idx = idx + 2'd1;
            if (!w_found && inReq[idx]) begin
                w_winner = idx;
                w_found  = 1'b1;
            end
        end
    end

    assign w_win_slice = inData[{w_winner, 5'b0} +: 32];
    assign w_gnt_slice = inData[{r_last, 5'b0} +: 32];
    assign w_req_held  = |(inReq & r_grant);
    assign w_other     = |(inReq & ~r_grant);
    assign w_sat       = (r_cnt == HOLD_MAX);

    always_comb begin
        r_state_d = r_state;
        r_last_d  = r_last;
        r_cnt_d   = r_cnt;
        r_grant_d = r_grant;
        r_value_d = r_value;
        case (r_state)
            ST_IDLE, ST_SWITCH: begin
                if (w_found) begin
                    r_state_d = ST_GRANT;
                    r_grant_d = 4'b0001 << w_winner;
                    r_last_d  = w_winner;
                    r_cnt_d   = '0;
                    if (!inFreeze) begin
                        r_value_d = w_win_slice;
                    end
                end else begin
                    r_state_d = ST_IDLE;
                    r_grant_d = 4'b0000;
                end
            end
            ST_GRANT: begin
                r_cnt_d = w_sat ? r_cnt : r_cnt + 1'b1;
                if (!inFreeze) begin
                    r_value_d = w_gnt_slice;
                end
                // A dropped request leaves at once; otherwise only yield once the hold is served.
                if (!w_req_held || (w_sat && w_other)) begin
                    r_state_d = ST_SWITCH;
                    r_grant_d = 4'b0000;
                end
            end
            default: begin
                r_state_d = ST_IDLE;
                r_grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge inClk or negedge inRstn) begin
        if (!inRstn) begin
            r_state <= ST_IDLE;
            r_last  <= 2'd3;
            r_cnt   <= '0;
            r_grant <= 4'b0000;
            r_value <= 32'h0;
        end else begin
            r_state <= r_state_d;
            r_last  <= r_last_d;
            r_cnt   <= r_cnt_d;
            r_grant <= r_grant_d;
            r_value <= r_value_d;
        end
    end

    assign outGrant = r_grant;
    assign outValue = r_value;
    assign outBusy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter with HOLD_CYCLES=4.
module tb_hex_display_arbiter;

    logic         inClk;
    logic         inRstn;
    logic [3:0]   inReq;
    logic [127:0] inData;
    logic         inFreeze;
    logic [3:0]   outGrant;
    logic [31:0]  outValue;
    logic         outBusy;

    int n_tests = 0;
    int n_fail  = 0;

    hex_display_arbiter #(
        .HOLD_CYCLES(4)
    ) dut (
        .inClk    (inClk),
        .inRstn   (inRstn),
        .inReq    (inReq),
        .inData   (inData),
        .inFreeze (inFreeze),
        .outGrant (outGrant),
        .outValue (outValue),
        .outBusy  (outBusy)
    );

    initial begin
        inClk = 1'b0;
        forever #5 inClk = ~inClk;
    end

    always @(negedge inClk) begin
        if (inRstn) begin
            n_tests++;
            if (!$onehot0(outGrant)) begin
                n_fail++;
                $display("FAIL onehot0: outGrant=%b required zero or one-hot", outGrant);
            end
        end
    end

    task automatic tick();
        @(posedge inClk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [3:0] g, input logic [31:0] v,
                             input logic b);
        n_tests++;
        if (outGrant !== g || outValue !== v || outBusy !== b) begin
            n_fail++;
            $display("FAIL %s: grant=%b value=%h busy=%b, required grant=%b value=%h busy=%b",
                     name, outGrant, outValue, outBusy, g, v, b);
        end
    endtask

    task automatic do_reset();
        @(negedge inClk);
        inRstn   = 1'b0;
        inReq    = 4'b0000;
        inFreeze = 1'b0;
        inData   = '0;
        #2;
        @(negedge inClk);
        inRstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        check_out("reset", 4'b0000, 32'h0, 1'b0);
        tick();
        check_out("idle_no_req", 4'b0000, 32'h0, 1'b0);
    endtask

    task automatic test_basic();
        do_reset();
        inReq         = 4'b0001;
        inData[31:0]  = 32'h12345678;
        tick();
        check_out("basic_grant", 4'b0001, 32'h12345678, 1'b1);
        inReq = 4'b0000;
        tick();
        check_out("basic_switch", 4'b0000, 32'h12345678, 1'b1);
        tick();
        check_out("basic_idle", 4'b0000, 32'h12345678, 1'b0);
    endtask

    task automatic test_contention();
        logic [3:0] exp_seq [12];
        exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                    4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
        do_reset();
        inData[31:0]  = 32'h11111111;
        inData[63:32] = 32'h22222222;
        inReq         = 4'b0011;
        for (int c = 0; c < 26; c++) begin
            tick();
            n_tests++;
            if (outGrant !== exp_seq[c % 12]) begin
                n_fail++;
                $display("FAIL contention cycle %0d: grant=%b required %b",
                         c, outGrant, exp_seq[c % 12]);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        inData[95:64] = 32'h00C0FFEE;
        inReq         = 4'b0100;
        for (int c = 0; c < 12; c++) begin
            tick();
        end
        check_out("saturate_hold", 4'b0100, 32'h00C0FFEE, 1'b1);
    endtask

    task automatic test_drop();
        do_reset();
        inData[95:64] = 32'hCAFEF00D;
        inReq         = 4'b0100;
        tick();
        check_out("drop_grant", 4'b0100, 32'hCAFEF00D, 1'b1);
        tick();
        inReq = 4'b0000;
        tick();
        check_out("drop_switch", 4'b0000, 32'hCAFEF00D, 1'b1);
        inData[95:64] = 32'h0BADBEEF;
        tick();
        check_out("drop_idle", 4'b0000, 32'hCAFEF00D, 1'b0);
    endtask

    task automatic test_freeze();
        do_reset();
        inData[63:32] = 32'hAAAA0000;
        inReq         = 4'b0010;
        tick();
        check_out("freeze_grant", 4'b0010, 32'hAAAA0000, 1'b1);
        inFreeze      = 1'b1;
        inData[63:32] = 32'hBBBB0000;
        tick();
        check_out("freeze_hold1", 4'b0010, 32'hAAAA0000, 1'b1);
        tick();
        check_out("freeze_hold2", 4'b0010, 32'hAAAA0000, 1'b1);
        inFreeze = 1'b0;
        tick();
        check_out("freeze_release", 4'b0010, 32'hBBBB0000, 1'b1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        inData[31:0]  = 32'h00000001;
        inData[63:32] = 32'h00000002;
        inReq         = 4'b0001;
        tick();
        check_out("b2b_first", 4'b0001, 32'h00000001, 1'b1);
        inReq = 4'b0010;
        tick();
        check_out("b2b_switch", 4'b0000, 32'h00000001, 1'b1);
        tick();
        check_out("b2b_second", 4'b0010, 32'h00000002, 1'b1);
    endtask

    task automatic test_async_reset();
        do_reset();
        inData[127:96] = 32'hDEADBEEF;
        inReq          = 4'b1000;
        tick();
        check_out("ar_grant", 4'b1000, 32'hDEADBEEF, 1'b1);
        #2;
        inRstn = 1'b0;
        #1;
        check_out("ar_async", 4'b0000, 32'h0, 1'b0);
        inReq = 4'b1111;
        @(negedge inClk);
        inRstn = 1'b1;
        tick();
        check_out("ar_first_after", 4'b0001, 32'h0, 1'b1);
    endtask

    initial begin
        inRstn   = 1'b0;
        inReq    = 4'b0000;
        inData   = '0;
        inFreeze = 1'b0;
        test_reset();
        test_basic();
        test_contention();
        test_saturate();
        test_drop();
        test_freeze();
        test_back_to_back();
        test_async_reset();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_display_arbiter.md
HEX_DISPLAY_ARBITER -- requirements
Module: hex_display_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 1000, which sets the minimum grant count under contention; legal values are >= 1.
REQ-002 The block SHALL have port inClk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port inRstn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port inReq, input, 4 bits: requester i is requesting the display while bit i is high.
REQ-005 The block SHALL have port inData, input, 128 bits: requester i's value is [32i+31:32i].
REQ-006 The block SHALL have port inFreeze, input, 1 bit: while high, outValue is not updated.
REQ-007 The block SHALL have port outGrant, output, 4 bits: one-hot or zero, registered.
REQ-008 The block SHALL have port outValue, output, 32 bits: registered display word, 8 nibbles for the eight seven-segment digits.
REQ-009 The block SHALL have port outBusy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-010 The block SHALL implement three states: IDLE, GRANT and SWITCH.
REQ-011 The block SHALL keep a 2-bit round-robin pointer lastGnt; the winner is the first set inReq bit searched in order lastGnt+1, lastGnt+2, lastGnt+3, lastGnt (mod 4).
REQ-012 In IDLE with any inReq bit set, the block SHALL, on the next edge, enter GRANT, set outGrant to the one-hot winner, set lastGnt to the winner, clear the hold counter, and load outValue from the winner's inData slice unless inFreeze is high.
REQ-013 In IDLE with inReq equal to 0, the block SHALL stay in IDLE with outGrant 0 and outValue held.
REQ-014 Grant latency SHALL be 1 cycle: a request seen in IDLE at edge N appears on outGrant after edge N.
REQ-015 In GRANT, the block SHALL load outValue every cycle from the granted slice unless inFreeze is high, so outValue lags inData by 1 cycle.
REQ-016 The hold counter SHALL increment once per GRANT cycle, saturate at HOLD_CYCLES, and have width $clog2(HOLD_CYCLES+1).
REQ-017 In GRANT, if the granted inReq bit is low, the block SHALL enter SWITCH on the next edge regardless of the counter value.
REQ-018 In GRANT, if the counter equals HOLD_CYCLES and any other inReq bit is high, the block SHALL enter SWITCH on the next edge (preemption).
REQ-019 Under contention, outGrant for one requester SHALL be high for exactly HOLD_CYCLES+1 consecutive cycles.
REQ-020 In GRANT with the counter saturated and no other request, the grant SHALL persist indefinitely.
REQ-021 SWITCH SHALL last exactly 1 cycle, with outGrant 0, outBusy 1 and outValue held.
REQ-022 From SWITCH, the block SHALL enter GRANT to the round-robin winner per REQ-012 if any inReq bit is set, else IDLE; the previous holder may win again only if it is the sole requester.
REQ-023 When the granted request drops and another request rises in the same cycle, the block SHALL follow REQ-017 (SWITCH first, then arbitrate).
REQ-024 inFreeze SHALL affect only outValue; arbitration, grants and counters SHALL proceed unchanged.
REQ-025 outGrant SHALL never have more than one bit set.

Reset
REQ-026 When inRstn is low, the block SHALL immediately force state to IDLE, outGrant to 0, outValue to 32'h0, outBusy to 0, the hold counter to 0 and lastGnt to 3, so requester 0 has first priority.
REQ-027 Reset asserted mid-GRANT or mid-SWITCH SHALL abort the operation without waiting for a clock edge; after deassertion the first edge SHALL behave per IDLE rules.

Verification
REQ-028 Reset then inReq=4'b0001, inData[31:0]=32'h12345678 -> one edge later outGrant=0001, outValue=32'h12345678, outBusy=1.
REQ-029 HOLD_CYCLES=4; inReq=4'b0011 held constantly from IDLE -> outGrant 0001 for 5 cycles, 0000 for 1 cycle, 0010 for 5 cycles, 0000 for 1 cycle, then 0001 again, repeating.
REQ-030 Requester 2 granted, inReq[2] drops at cycle 2 with no other requests -> SWITCH for 1 cycle, then IDLE; outValue holds its last value and outBusy=0.
REQ-031 Requester 1 granted with inFreeze=1 and inData[63:32] changing from 32'hAAAA0000 to 32'hBBBB0000 -> outValue stays 32'hAAAA0000; after inFreeze drops, outValue shows 32'hBBBB0000 one cycle later.
REQ-032 inRstn pulsed low mid-GRANT between clock edges -> outGrant=0, outValue=0 and outBusy=0 without waiting for an edge; after release with inReq=4'b1111 -> grant 0001 first.
REQ-033 All scenarios -> outGrant is zero or one-hot on every cycle (assertion).
